// File: rtl/pipe_rc_adder_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipe_rc_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry add/subtract: each stage resolves SEG_W sum bits and
// registers its carry, with a valid/ready elastic pipeline around the datapath.
module pipe_rc_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input logic            clk,
  input logic            rst,
  pipe_rc_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SEG_W;
  localparam int MSB    = WIDTH - 1;
  localparam int LAST   = STAGES - 1;

  function automatic logic [SEG_W:0] ripple_add(input logic [SEG_W-1:0] x,
                                                input logic [SEG_W-1:0] y,
                                                input logic             c);
    logic [SEG_W:0] r;
    logic           cy;
    cy = c;
    for (int i = 0; i < SEG_W; i++) begin
      r[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    r[SEG_W] = cy;
    return r;
  endfunction

  // Per-stage registers: a_p/b_p hold the unused operand bits shifted down so
  // the next segment sits at the LSBs; s_p holds sum bits already resolved.
  logic [STAGES-1:0] vld_p;
  logic              c_p  [STAGES];
  logic [WIDTH-1:0]  s_p  [STAGES];
  logic [WIDTH-1:0]  a_p  [STAGES];
  logic [WIDTH-1:0]  b_p  [STAGES];
  logic              am_p [STAGES];
  logic              bm_p [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] vin_c;
  logic              c_nx  [STAGES];
  logic [WIDTH-1:0]  s_nx  [STAGES];
  logic [WIDTH-1:0]  a_nx  [STAGES];
  logic [WIDTH-1:0]  b_nx  [STAGES];
  logic              am_nx [STAGES];
  logic              bm_nx [STAGES];

  // A stage may move when it or any stage after it has a hole, or the sink takes.
  always_comb begin
    logic full;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) full = full & vld_p[j];
      adv[k] = bus.out_ready | ~full;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] ai, bi, si;
    logic             ci, ami, bmi;
    logic [SEG_W:0]   r;
    int               p;
    for (int k = 0; k < STAGES; k++) begin
      p        = (k > 0) ? k - 1 : 0;
      vin_c[k] = (k == 0) ? bus.in_valid : vld_p[p];
      ai       = (k == 0) ? bus.a : a_p[p];
      bi       = (k == 0) ? (bus.b ^ {WIDTH{bus.sub}}) : b_p[p];
      si       = (k == 0) ? '0 : s_p[p];
      ci       = (k == 0) ? (bus.sub | bus.cin) : c_p[p];
      ami      = (k == 0) ? bus.a[MSB] : am_p[p];
      bmi      = (k == 0) ? (bus.b[MSB] ^ bus.sub) : bm_p[p];
      r        = ripple_add(ai[SEG_W-1:0], bi[SEG_W-1:0], ci);
      s_nx[k]  = si;
      s_nx[k][k*SEG_W +: SEG_W] = r[SEG_W-1:0];
      c_nx[k]  = r[SEG_W];
      a_nx[k]  = ai >> SEG_W;
      b_nx[k]  = bi >> SEG_W;
      am_nx[k] = ami;
      bm_nx[k] = bmi;
    end
  end

  // Stage register boundary: valid bits are reset, datapath only loads.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        vld_p[k] <= 1'b0;
      end else if (adv[k]) begin
        vld_p[k] <= vin_c[k];
      end
      if (adv[k] && vin_c[k]) begin
        c_p[k]  <= c_nx[k];
        s_p[k]  <= s_nx[k];
        a_p[k]  <= a_nx[k];
        b_p[k]  <= b_nx[k];
        am_p[k] <= am_nx[k];
        bm_p[k] <= bm_nx[k];
      end
    end
  end

  // Result fields are forced to zero whenever no result is presented.
  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_p[LAST];
  assign bus.sum       = vld_p[LAST] ? s_p[LAST] : '0;
  assign bus.cout      = vld_p[LAST] & c_p[LAST];
  assign bus.ovf       = vld_p[LAST] & (am_p[LAST] == bm_p[LAST]) &
                         (s_p[LAST][MSB] != am_p[LAST]);
endmodule

// File: doc/pipe_rc_adder.md
PIPE_RC_ADDER -- requirements
Module: pipe_rc_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of SEG_W and at least SEG_W.
REQ-002 Parameter SEG_W, default 4: bits resolved per pipeline stage; STAGES = WIDTH/SEG_W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in, used only when sub=0.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result on sum, cout, ovf is valid.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-014 cout  output  1  raw carry out of the MSB.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Accept an operand set when in_valid and in_ready are both high; complete the result when out_valid and out_ready are both high.
REQ-017 Arithmetic with sub=0: {cout,sum} = a + b + cin.
REQ-018 Arithmetic with sub=1: {cout,sum} = a + ~b + 1, with cin ignored; cout=1 means no borrow.
REQ-019 ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = sub ? ~b : b.
REQ-020 Stage k (0..STAGES-1) holds a valid bit and resolves bits [k*SEG_W +: SEG_W] using the carry registered from stage k-1.
- Stage 0 uses cin, or 1 when sub=1.
- Each stage's carry output is a ripple chain of 1-bit full adders.
REQ-021 Stage k SHALL also carry forward the already-resolved lower sum bits, the not-yet-used upper operand bits (with b already conditionally inverted) and the operand MSBs needed for ovf.
REQ-022 Latency: a set accepted in cycle T SHALL present out_valid in cycle T+STAGES when there is no backpressure.
REQ-023 Throughput: one operand set per cycle while out_ready=1.
REQ-024 Stage k SHALL advance when it is empty or stage k+1 advances; the last stage advances when it is empty or out_ready=1.
REQ-025 in_ready = stage 0 advance condition; in_ready SHALL NOT depend combinationally on in_valid.
REQ-026 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL hold stable, and no queued result SHALL be dropped or duplicated.
REQ-027 A full pipeline with out_ready=0 SHALL hold in_ready=0.
REQ-028 When the pipeline is full and out_ready rises, in_ready SHALL rise in the same cycle (simultaneous accept and retire).
REQ-029 Results SHALL emerge in acceptance order.
REQ-030 When STAGES=1, the block SHALL be a single registered stage with latency 1.

Reset
REQ-031 With rst high at a clock edge, all stage valid bits SHALL clear: out_valid=0, and sum, cout, ovf = 0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight sets; no result of a pre-reset set SHALL appear.
REQ-034 rst takes priority over in_valid and out_ready in the same cycle.

Verification (WIDTH=16, SEG_W=4)
REQ-035 Bench: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
REQ-036 Bench: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; then a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0.
REQ-037 Bench: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-038 Bench: stream 8 back-to-back sets with out_ready=0 -> in_ready drops after 4 accepts; then raise out_ready -> 8 results in order, one per cycle, with no gaps while in_valid stays high.
REQ-039 Bench: 2 sets in flight, assert rst for 1 cycle -> out_valid stays 0 afterwards and in_ready=1.
REQ-040 Bench: 10,000 random sets with random in_valid/out_ready -> every result matches the REQ-017..REQ-019 model, in order.
